// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one result bit per clock,
// with a valid/ready handshake toward the display stage.
module result_bcd_converter #(
   parameter int width  = 8,
   parameter int digits = 5
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [2*width-1:0]    value_i,
   input  logic                  sign_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [4*digits-1:0]   bcd_o,
   output logic                  sign_o,
   output logic                  overflow_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   localparam int CW = $clog2(2*width+1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [2*width-1:0]    r_shift;
   logic [4*digits-1:0]   r_scratch;
   logic                  r_ovf;
   logic                  r_sign;
   logic [CW-1:0]         r_cnt;
   logic [4*digits-1:0]   r_bcd;
   logic                  r_sign_out;
   logic                  r_ovf_out;
   logic                  r_valid;
   logic                  r_ready;

   logic [4*digits-1:0]   w_adj;
   logic [4*digits-1:0]   w_next_scratch;
   logic                  w_next_ovf;

   function automatic logic [3:0] add3(input logic [3:0] d);
      if (d >= 4'd5) begin
         return d + 4'd3;
      end else begin
         return d;
      end
   endfunction

   // Add-3 correction on every scratch digit ahead of the shift
   always_comb begin
      w_adj = r_scratch;
      for (int k = 0; k < digits; k++) begin
         w_adj[4*k +: 4] = add3(r_scratch[4*k +: 4]);
      end
   end

   // A carry out of the top digit is a whole multiple of 10^digits lost
   assign w_next_scratch = {w_adj[4*digits-2:0], r_shift[2*width-1]};
   assign w_next_ovf     = r_ovf | w_adj[4*digits-1];

   // Conversion FSM and registered handshake outputs
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_shift    <= {(2*width){1'b0}};
         r_scratch  <= {(4*digits){1'b0}};
         r_ovf      <= 1'b0;
         r_sign     <= 1'b0;
         r_cnt      <= {CW{1'b0}};
         r_bcd      <= {(4*digits){1'b0}};
         r_sign_out <= 1'b0;
         r_ovf_out  <= 1'b0;
         r_valid    <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid_i) begin
                  r_shift   <= value_i;
                  r_scratch <= {(4*digits){1'b0}};
                  r_ovf     <= 1'b0;
                  r_sign    <= sign_i;
                  r_cnt     <= CW'(2*width);
                  r_ready   <= 1'b0;
                  r_state   <= S_CONV;
               end
            end
            S_CONV: begin
               r_shift   <= {r_shift[2*width-2:0], 1'b0};
               r_scratch <= w_next_scratch;
               r_ovf     <= w_next_ovf;
               r_cnt     <= r_cnt - CW'(1);
               // Last bit: publish the post-shift scratch directly
               if (r_cnt == CW'(1)) begin
                  r_bcd      <= w_next_scratch;
                  r_ovf_out  <= w_next_ovf;
                  r_sign_out <= r_sign;
                  r_valid    <= 1'b1;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o    = r_ready;
   assign bcd_o      = r_bcd;
   assign sign_o     = r_sign_out;
   assign overflow_o = r_ovf_out;
   assign valid_o    = r_valid;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: a 5-digit and a 4-digit instance
// share one input stream; expected BCD values are hand-computed constants.
module tb_result_bcd_converter;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic        sign;
   logic        valid_in;
   logic        ready_in;

   logic        ready5, sign5, ovf5, valid5;
   logic [19:0] bcd5;
   logic        ready4, sign4, ovf4, valid4;
   logic [15:0] bcd4;

   int checks   = 0;
   int failures = 0;
   int lat;

   result_bcd_converter #(.width(8), .digits(5)) dut5 (
      .clock_i(clk), .reset_i(rst), .value_i(value), .sign_i(sign),
      .valid_i(valid_in), .ready_o(ready5), .bcd_o(bcd5), .sign_o(sign5),
      .overflow_o(ovf5), .valid_o(valid5), .ready_i(ready_in)
   );

   result_bcd_converter #(.width(8), .digits(4)) dut4 (
      .clock_i(clk), .reset_i(rst), .value_i(value), .sign_i(sign),
      .valid_i(valid_in), .ready_o(ready4), .bcd_o(bcd4), .sign_o(sign4),
      .overflow_o(ovf4), .valid_o(valid4), .ready_i(ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic digits_ok(input logic [19:0] b);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (b[4*k +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Present one value when ready, then measure edges until valid_o
   task automatic send(input logic [15:0] v, input logic s, input logic noise, output int latency);
      int w;
      w = 0;
      while (!ready5 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("ready_before_send", {31'd0, ready5}, 32'd1);
      value    = v;
      sign     = s;
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("ready_low_in_conv", {31'd0, ready5}, 32'd0);
      latency = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (valid5) begin
            latency = n;
            break;
         end
         if (noise) begin
            valid_in = n[0];
            value    = 16'h0777;
            sign     = ~s;
         end
      end
      valid_in = 1'b0;
      chk("latency", latency, 32'd16);
      chk("digit_range", {31'd0, digits_ok(bcd5)}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; value = 16'd0; sign = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, ready5}, 32'd1);
      chk("rst_valid", {31'd0, valid5}, 32'd0);
      chk("rst_bcd", {12'd0, bcd5}, 32'h0);
      chk("rst_sign", {31'd0, sign5}, 32'd0);
      chk("rst_ovf", {31'd0, ovf5}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // zero
      send(16'd0, 1'b0, 1'b0, lat);
      chk("zero_bcd", {12'd0, bcd5}, 32'h00000);
      chk("zero_ovf", {31'd0, ovf5}, 32'd0);
      chk("zero_sign", {31'd0, sign5}, 32'd0);
      @(posedge clk); #1;

      // max value, one-cycle valid with ready_i high
      send(16'd65535, 1'b1, 1'b0, lat);
      chk("max_bcd", {12'd0, bcd5}, 32'h65535);
      chk("max_sign", {31'd0, sign5}, 32'd1);
      chk("max_ovf", {31'd0, ovf5}, 32'd0);
      chk("max_ready_in_done", {31'd0, ready5}, 32'd0);
      @(posedge clk); #1;
      chk("max_valid_drop", {31'd0, valid5}, 32'd0);
      chk("max_ready_back", {31'd0, ready5}, 32'd1);
      chk("max_hold_bcd", {12'd0, bcd5}, 32'h65535);

      // backpressure with stray valid_i pulses during CONV and DONE
      ready_in = 1'b0;
      send(16'd12345, 1'b0, 1'b1, lat);
      chk("bp_bcd", {12'd0, bcd5}, 32'h12345);
      for (int c = 0; c < 10; c++) begin
         valid_in = c[0];
         value    = 16'd999;
         @(posedge clk); #1;
         chk("bp_hold_bcd", {12'd0, bcd5}, 32'h12345);
         chk("bp_hold_valid", {31'd0, valid5}, 32'd1);
         chk("bp_hold_ready", {31'd0, ready5}, 32'd0);
         chk("bp_hold_sign", {31'd0, sign5}, 32'd0);
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'd0, valid5}, 32'd0);
      chk("bp_release_ready", {31'd0, ready5}, 32'd1);
      chk("bp_keep_bcd", {12'd0, bcd5}, 32'h12345);

      // back-to-back
      send(16'd9, 1'b0, 1'b0, lat);
      chk("b2b_9", {12'd0, bcd5}, 32'h00009);
      @(posedge clk); #1;
      send(16'd100, 1'b1, 1'b0, lat);
      chk("b2b_100", {12'd0, bcd5}, 32'h00100);
      chk("b2b_100_sign", {31'd0, sign5}, 32'd1);
      @(posedge clk); #1;

      // reset mid-conversion
      value = 16'd4321; sign = 1'b1; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ready", {31'd0, ready5}, 32'd1);
      chk("abort_valid", {31'd0, valid5}, 32'd0);
      chk("abort_bcd", {12'd0, bcd5}, 32'h0);
      chk("abort_sign", {31'd0, sign5}, 32'd0);
      chk("abort_ovf", {31'd0, ovf5}, 32'd0);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", {31'd0, valid5}, 32'd0);
      end
      send(16'd42, 1'b0, 1'b0, lat);
      chk("after_abort_42", {12'd0, bcd5}, 32'h00042);
      @(posedge clk); #1;

      // 4-digit instance overflow boundary
      send(16'd10000, 1'b0, 1'b0, lat);
      chk("d4_10000_ovf", {31'd0, ovf4}, 32'd1);
      chk("d4_10000_bcd", {16'd0, bcd4}, 32'h0000);
      chk("d4_10000_valid", {31'd0, valid4}, 32'd1);
      chk("d5_10000_bcd", {12'd0, bcd5}, 32'h10000);
      chk("d5_10000_ovf", {31'd0, ovf5}, 32'd0);
      @(posedge clk); #1;
      send(16'd9999, 1'b0, 1'b0, lat);
      chk("d4_9999_ovf", {31'd0, ovf4}, 32'd0);
      chk("d4_9999_bcd", {16'd0, bcd4}, 32'h9999);
      @(posedge clk); #1;
      send(16'd65535, 1'b0, 1'b0, lat);
      chk("d4_65535_ovf", {31'd0, ovf4}, 32'd1);
      chk("d4_65535_bcd", {16'd0, bcd4}, 32'h5535);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Downstream stage of the calculator datapath: takes the registered ALU result (2*width bits) and its sign flag.
- Converts the result to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, one bit per clock.
- Presents the digits and sign to the display stage through a valid/ready handshake.
- Frees the calculator core from any decimal formatting logic.

Parameters:
- width, 8: calculator operand width; converted input is 2*width bits.
- digits, 5: number of BCD output digits; 5 covers 2*width = 16.

Ports:
- clock_i  input  1  system clock, all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- value_i  input  2*width  unsigned result magnitude from the calculator result register
- sign_i  input  1  sign/flag bit from the calculator signal register, passed through
- valid_i  input  1  value_i/sign_i valid this cycle
- ready_o  output  1  block can accept a new value (high only in IDLE)
- bcd_o  output  4*digits  packed BCD, digit 0 in bits [3:0]
- sign_o  output  1  latched sign_i of the converted value
- overflow_o  output  1  value_i does not fit in digits BCD digits
- valid_o  output  1  bcd_o/sign_o/overflow_o hold a fresh result
- ready_i  input  1  downstream consumes result when high with valid_o

Behaviour:
- Reset (reset_i=1 at a rising edge): state IDLE; bcd_o=0, sign_o=0, overflow_o=0, valid_o=0; ready_o=1 after the edge. Reset wins over every other input in the same cycle, including mid-conversion (conversion aborted, no result emitted).
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i=1, load value_i into the shift register, clear the BCD scratch register and scratch overflow bit, latch sign_i, set bit counter = 2*width, go to CONV.
- CONV:
  - ready_o=0; valid_i ignored.
  - Each cycle: every scratch digit >= 5 gets +3, then {scratch, shift} shifts left by one. The bit shifted out of the top scratch digit ORs into the scratch overflow bit. Counter decrements.
  - When the counter reaches 1 on a shift cycle, go to DONE on that edge, copying scratch to bcd_o, overflow to overflow_o, and latched sign to sign_o.
- Latency: valid_o rises exactly 2*width clock edges after the accepting edge (16 for width=8).
- DONE:
  - valid_o=1, ready_o=0.
  - bcd_o, sign_o, overflow_o stay stable while ready_i=0, with unlimited backpressure.
  - On ready_i=1, go to IDLE; valid_o=0 after that edge.
  - A new value can be accepted no earlier than the cycle after the handshake.
- bcd_o, sign_o, overflow_o keep the last result after leaving DONE until the next DONE entry or reset. valid_o marks freshness only.
- All outputs are registered; no combinational path from inputs to outputs.
- Boundaries:
  - value_i=0 gives all-zero digits.
  - Maximum value 2^(2*width)-1 must convert with no overflow when digits >= ceil(2*width*log10(2)).
  - With too few digits, overflow_o=1 and bcd_o holds the value modulo 10^digits.
  - A digit value >9 in bcd_o is a design error; the verification engineer asserts on it.

Test Plan:
- Reset, then value_i=16'd0, sign_i=0, valid_i=1 for one cycle -> valid_o high 16 edges later; bcd_o=20'h00000, overflow_o=0, sign_o=0.
- value_i=16'd65535, sign_i=1, ready_i=1 -> bcd_o=20'h65535, sign_o=1, valid_o exactly one cycle, ready_o back to 1 the next cycle.
- value_i=16'd12345 with ready_i=0 for 10 cycles after valid_o -> bcd_o=20'h12345 stable throughout; valid_i pulses during CONV/DONE ignored (ready_o=0); result delivered on ready_i=1.
- Back-to-back: 16'd9 then 16'd100, each presented when ready_o=1 -> outputs 20'h00009 then 20'h00100, each with 16-cycle latency.
- reset_i=1 on cycle 7 of a conversion of 16'd4321 -> valid_o never rises for it; outputs 0, ready_o=1; next value 16'd42 gives 20'h00042.
- digits=4, value_i=16'd10000 -> overflow_o=1, bcd_o=16'h0000; value_i=16'd9999 -> overflow_o=0, bcd_o=16'h9999.
